// File: rtl/proc_pkg.sv
// Shared types and constants for the proc instruction sequencer.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // mvi occupies the instruction word plus one immediate word.
    localparam int MVI_WORDS = 2;

endpackage

// File: rtl/prog_mem.sv
// Program store: synchronous write, two asynchronous read ports (pc and pc+1).
module prog_mem #(
    parameter int DW = 6,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr0,
    input  logic [AW-1:0] i_raddr1,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/proc_sequencer.sv
// Sequencer that steps the proc datapath through a stored program.
// Optional EXEC watchdog enabled by defining PROC_SEQ_WATCHDOG_EN.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int DATAWIDTH = 6,
    parameter int AW        = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic [AW:0]          prog_len,
    input  logic                 ld_we,
    input  logic [AW-1:0]        ld_addr,
    input  logic [DATAWIDTH-1:0] ld_data,
    output logic [DATAWIDTH-1:0] DIN,
    output logic                 Run,
    input  logic                 Done,
    output logic                 busy,
    output logic                 halted,
    output logic                 err,
    output logic [AW-1:0]        pc,
    output logic [15:0]          instr_cnt,
    output logic [2:0]           dbg_state
);

    state_e               r_state;
    logic [AW-1:0]        r_pc;
    logic [AW:0]          r_len;
    logic [1:0]           r_op;
    logic [15:0]          r_cnt;

    logic [DATAWIDTH-1:0] w_word;
    logic [DATAWIDTH-1:0] w_imm;
    logic [AW-1:0]        w_pc1;
    logic [AW:0]          w_pc1_ext;
    logic [AW:0]          w_step;
    logic [AW:0]          w_npc;
    logic                 w_busy;
    logic                 w_we;
    logic                 w_word_mvi;
    logic                 w_wd_expired;

    assign w_busy     = (r_state == ST_ISSUE) || (r_state == ST_EXEC);
    assign w_we       = ld_we && !w_busy;
    assign w_pc1      = r_pc + AW'(1);
    assign w_pc1_ext  = {1'b0, r_pc} + (AW+1)'(1);
    assign w_word_mvi = (w_word[DATAWIDTH-1 -: 2] == OP_MVI);
    assign w_step     = (r_op == OP_MVI) ? (AW+1)'(MVI_WORDS) : (AW+1)'(1);
    assign w_npc      = {1'b0, r_pc} + w_step;

    prog_mem #(
        .DW (DATAWIDTH),
        .AW (AW)
    ) u_prog_mem (
        .i_clk    (Clock),
        .i_we     (w_we),
        .i_waddr  (ld_addr),
        .i_wdata  (ld_data),
        .i_raddr0 (r_pc),
        .i_raddr1 (w_pc1),
        .o_rdata0 (w_word),
        .o_rdata1 (w_imm)
    );

`ifdef PROC_SEQ_WATCHDOG_EN
    logic [1:0] r_wd;

    // Counts EXEC cycles; zero in the first EXEC cycle of every instruction.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_wd <= '0;
        end else if (r_state != ST_EXEC) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 2'd1;
        end
    end

    assign w_wd_expired = (r_wd == 2'd3);
`else
    assign w_wd_expired = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_op    <= OP_MV;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT, ST_ERR: begin
                    if (start) begin
                        if (prog_len == '0) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_pc    <= '0;
                            r_cnt   <= '0;
                            r_len   <= prog_len;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_op <= w_word[DATAWIDTH-1 -: 2];
                    if (w_word_mvi && (w_pc1_ext >= r_len)) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (Done) begin
                        if (r_cnt != 16'hFFFF) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                        // stop wins over loop at the end of the program.
                        if (w_npc >= r_len) begin
                            if (loop && !stop) begin
                                r_pc    <= '0;
                                r_state <= ST_ISSUE;
                            end else begin
                                r_state <= ST_HALT;
                            end
                        end else if (stop) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_pc    <= w_npc[AW-1:0];
                            r_state <= ST_ISSUE;
                        end
                    end else if (w_wd_expired) begin
                        r_state <= ST_ERR;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        DIN = '0;
        case (r_state)
            ST_ISSUE: DIN = w_word;
            ST_EXEC:  DIN = (r_op == OP_MVI) ? w_imm : '0;
            default:  DIN = '0;
        endcase
    end

    assign Run       = (r_state == ST_ISSUE);
    assign busy      = w_busy;
    assign halted    = (r_state == ST_HALT);
    assign err       = (r_state == ST_ERR);
    assign pc        = r_pc;
    assign instr_cnt = r_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: program-level reference model feeding an issue scoreboard.
module tb_proc_sequencer;

    logic        Clock;
    logic        Resetn;
    logic        start;
    logic        stop;
    logic        loop;
    logic [4:0]  prog_len;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [5:0]  ld_data;
    logic [5:0]  DIN;
    logic        Run;
    logic        Done;
    logic        busy;
    logic        halted;
    logic        err;
    logic [3:0]  pc;
    logic [15:0] instr_cnt;
    logic [2:0]  dbg_state;

    typedef struct packed {
        logic [3:0] pc;
        logic [5:0] word;
        logic [5:0] exec_din;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    bit         mon_exec_pend;
    logic [5:0] mon_exec_exp;
    logic [5:0] tb_mem [16];
    int         n_checks;
    int         n_fail;
    int         stop_after;
    bit         done_en;
    int         runs;
    int         wait_cnt;

    proc_sequencer #(.DATAWIDTH(6), .AW(4)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .prog_len  (prog_len),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .DIN       (DIN),
        .Run       (Run),
        .Done      (Done),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .pc        (pc),
        .instr_cnt (instr_cnt),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // proc stand-in: mv/mvi finish in the first EXEC cycle, add/sub in the third.
    // Also raises stop once the chosen number of instructions has been issued.
    always @(negedge Clock) begin
        if (!Resetn) begin
            wait_cnt = 0;
            Done     = 1'b0;
            stop     = 1'b0;
            runs     = 0;
        end else begin
            if (start) begin
                runs = 0;
                stop = 1'b0;
            end
            if (Run) begin
                runs++;
                wait_cnt = (DIN[5:4] >= 2'd2) ? 3 : 1;
                Done     = 1'b0;
                if (stop_after != 0 && runs == stop_after) stop = 1'b1;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                Done = done_en && (wait_cnt == 0);
            end else begin
                Done = 1'b0;
            end
        end
    end

    // Monitor: every Run pulse pops the scoreboard; the following cycle checks the EXEC word.
    always @(negedge Clock) begin
        if (Resetn) begin
            if (mon_exec_pend) begin
                check("exec_din", {26'd0, DIN}, {26'd0, mon_exec_exp});
                mon_exec_pend = 1'b0;
            end
            if (Run) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_run", {26'd0, DIN}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("issue_pc", {28'd0, pc}, {28'd0, mon_e.pc});
                    check("issue_din", {26'd0, DIN}, {26'd0, mon_e.word});
                    mon_exec_exp  = mon_e.exec_din;
                    mon_exec_pend = 1'b1;
                end
            end
        end else begin
            mon_exec_pend = 1'b0;
        end
    end

    // Reference model: walks the program by its word-level rules and queues each issue.
    task automatic run_model(input int len, input int lp, input int sa,
                             output int cyc, output int cnt, output bit e);
        int         p;
        logic [5:0] w;
        bit         mvi;
        exp_t       ent;
        p = 0; cyc = 1; cnt = 0; e = 1'b0;
        if (len == 0) return;
        for (int guard = 0; guard < 1000; guard++) begin
            w   = tb_mem[p];
            mvi = (w[5:4] == 2'b01);
            ent.pc   = p[3:0];
            ent.word = w;
            if (mvi && (p + 1 >= len)) begin
                ent.exec_din = 6'd0;
                exp_q.push_back(ent);
                cyc += 1;
                e = 1'b1;
                return;
            end
            ent.exec_din = mvi ? tb_mem[(p + 1) % 16] : 6'd0;
            exp_q.push_back(ent);
            cyc += (w[5:4] >= 2'd2) ? 4 : 2;
            cnt++;
            if (cnt == sa) return;
            p = p + (mvi ? 2 : 1);
            if (p >= len) begin
                if (lp != 0) p = 0;
                else return;
            end
        end
    endtask

    // Driver tasks
    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Resetn = 1'b0;
        tick;
        Resetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic load_word(input int a, input logic [5:0] d);
        ld_we   = 1'b1;
        ld_addr = a[3:0];
        ld_data = d;
        tb_mem[a] = d;
        tick;
        ld_we = 1'b0;
    endtask

    task automatic run_prog(input string tag, input int len, input int lp, input int sa,
                            input bit busy_wr, input int co_addr, input logic [5:0] co_data);
        int exp_cyc;
        int exp_cnt;
        int cycles;
        bit exp_err;
        if (co_addr >= 0) tb_mem[co_addr] = co_data;
        run_model(len, lp, sa, exp_cyc, exp_cnt, exp_err);
        prog_len   = len[4:0];
        loop       = lp[0];
        stop_after = sa;
        start      = 1'b1;
        if (co_addr >= 0) begin
            ld_we = 1'b1; ld_addr = co_addr[3:0]; ld_data = co_data;
        end
        tick;
        start  = 1'b0;
        ld_we  = 1'b0;
        cycles = 1;
        while (!(halted || err) && cycles < 3000) begin
            if (busy_wr && cycles == 2) begin
                ld_we = 1'b1; ld_addr = 4'd0; ld_data = ~tb_mem[0];
            end
            tick;
            ld_we = 1'b0;
            cycles++;
        end
        tick;
        check({tag, "_cycles"}, cycles, exp_cyc);
        check({tag, "_halted"}, {31'd0, halted}, {31'd0, !exp_err});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_run"}, {31'd0, Run}, 32'd0);
        check({tag, "_din"}, {26'd0, DIN}, 32'd0);
        if (len > 0) check({tag, "_instr_cnt"}, {16'd0, instr_cnt}, exp_cnt);
        check({tag, "_queue_left"}, exp_q.size(), 32'd0);
        if (cycles >= 3000) do_reset;
    endtask

    task automatic load_basic;
        load_word(0, 6'h10);
        load_word(1, 6'h05);
        load_word(2, 6'h04);
        load_word(3, 6'h21);
    endtask

    initial begin
        int cyc;
        int cnt;
        bit e;
        int len;
        int lp;
        int sa;
        n_checks = 0; n_fail = 0;
        Resetn = 1'b0; start = 1'b0; loop = 1'b0; prog_len = '0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        stop_after = 0; done_en = 1'b1;
        repeat (3) tick;

        check("rst_din", {26'd0, DIN}, 32'd0);
        check("rst_run", {31'd0, Run}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_cnt", {16'd0, instr_cnt}, 32'd0);
        Resetn = 1'b1;
        tick;

        load_basic;
        run_prog("basic", 4, 0, 0, 1'b0, -1, 6'd0);
        run_prog("busy_write", 4, 0, 0, 1'b1, -1, 6'd0);
        run_prog("after_busy_write", 4, 0, 0, 1'b0, -1, 6'd0);

        load_word(0, 6'h18);
        run_prog("mvi_imm", 2, 0, 0, 1'b0, 1, 6'h3F);

        load_word(0, 6'h10);
        load_word(1, 6'h01);
        run_prog("loop_stop", 2, 1, 5, 1'b0, -1, 6'd0);

        load_word(0, 6'h10);
        run_prog("mvi_last", 1, 0, 0, 1'b0, -1, 6'd0);
        run_prog("len_zero", 0, 0, 0, 1'b0, -1, 6'd0);

        // Reset asserted in the second EXEC cycle of an add.
        load_word(0, 6'h21);
        run_model(1, 0, 0, cyc, cnt, e);
        prog_len = 5'd1; loop = 1'b0; stop_after = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("mid_add_busy", {31'd0, busy}, 32'd1);
        #2 Resetn = 1'b0;
        #1;
        check("mid_rst_run", {31'd0, Run}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_din", {26'd0, DIN}, 32'd0);
        check("mid_rst_pc", {28'd0, pc}, 32'd0);
        check("mid_rst_cnt", {16'd0, instr_cnt}, 32'd0);
        check("mid_rst_flags", {30'd0, halted, err}, 32'd0);
        tick;
        Resetn = 1'b1;
        exp_q.delete();
        load_basic;
        run_prog("post_reset", 4, 0, 0, 1'b0, -1, 6'd0);

        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < 16; a++) load_word(a, 6'($urandom_range(0, 63)));
            len = $urandom_range(1, 16);
            lp  = $urandom_range(0, 1);
            sa  = (lp != 0) ? $urandom_range(1, 12) : $urandom_range(0, 20);
            run_prog("rand", len, lp, sa, 1'b0, -1, 6'd0);
        end

        // Done never arrives.
        load_word(0, 6'h21);
        done_en = 1'b0;
        run_model(1, 0, 0, cyc, cnt, e);
        prog_len = 5'd1; loop = 1'b0; stop_after = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
`ifdef PROC_SEQ_WATCHDOG_EN
        while (!err && cyc < 50) begin
            tick;
            cyc++;
        end
        check("wd_err_cycle", cyc, 32'd6);
        check("wd_err", {31'd0, err}, 32'd1);
        check("wd_run", {31'd0, Run}, 32'd0);
        check("wd_busy", {31'd0, busy}, 32'd0);
`else
        repeat (100) begin
            tick;
            cyc++;
        end
        check("nowd_busy", {31'd0, busy}, 32'd1);
        check("nowd_err", {31'd0, err}, 32'd0);
        check("nowd_run", {31'd0, Run}, 32'd0);
`endif
        check("wd_queue_left", exp_q.size(), 32'd0);
        done_en = 1'b1;
        do_reset;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
